instr_loader: RTL and testbench

Program loader for the single-cycle processor: accepts instruction fields over a valid/ready stream, encodes each into the 17-bit machine-code word, and writes it sequentially into the 64-entry instruction memory. While loading, it holds the processor in reset. It is the writer side of the instruction format that the processor's instruction decoder reads.

---
 rtl/instr_loader_pkg.sv | 34 +++
 rtl/instr_loader_if.sv | 15 +
 rtl/instr_packer.sv | 41 ++++
 rtl/instr_loader.sv | 75 +++++++
 tb/tb_instr_loader.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/instr_loader_pkg.sv
// instr_pkg: opcodes, field positions and FSM state shared by the loader and the instruction decoder.
package instr_pkg;
  localparam int WORD_W = 17;
  localparam int OP_LO = 12;
  localparam int BODY_W = 12;
  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_ADDI = 5'b00010;
  localparam logic [4:0] OP_SUBI = 5'b00011;
  localparam logic [4:0] OP_MUL = 5'b00100;
  localparam logic [4:0] OP_DIV = 5'b00101;
  localparam logic [4:0] OP_CLR = 5'b00110;
  localparam logic [4:0] OP_RST = 5'b00111;
  localparam logic [4:0] OP_MOV = 5'b01000;
  localparam logic [4:0] OP_JMP = 5'b01001;
  localparam logic [4:0] OP_CMP = 5'b01010;
  localparam logic [4:0] OP_JZ = 5'b01011;
  localparam logic [4:0] OP_INC = 5'b01100;
  localparam logic [4:0] OP_DEC = 5'b01101;
  localparam logic [4:0] OP_LOAD = 5'b01110;
  localparam logic [4:0] OP_STORE = 5'b01111;
  localparam logic [4:0] OP_RIO = 5'b10000;
  localparam logic [4:0] OP_MOVI = 5'b10001;
  // Low bit of each field within the 12-bit operand body.
  localparam int S3_LO = 6;
  localparam int A3_LO = 3;
  localparam int SI_LO = 7;
  localparam int AI_LO = 4;
  localparam int HI_LO = 9;
  localparam int MID_LO = 6;
  localparam int DADDR_LO = 5;
  localparam int JADDR_LO = 6;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} state_t;
endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: valid/ready beat stream carrying one instruction's fields.
interface instr_loader_if;
  logic in_valid;
  logic in_ready;
  logic in_last;
  logic [4:0] op;
  logic [2:0] rs;
  logic [2:0] ra;
  logic [2:0] rb;
  logic [3:0] imm;
  logic [5:0] jaddr;
  logic [3:0] daddr;
  modport master(output in_valid, in_last, op, rs, ra, rb, imm, jaddr, daddr, input in_ready);
  modport slave(input in_valid, in_last, op, rs, ra, rb, imm, jaddr, daddr, output in_ready);
endinterface

// File: rtl/instr_packer.sv
// instr_packer: combinational encoder from instruction fields to the 17-bit machine word.
module instr_packer
  import instr_pkg::*;
(
  input  logic [4:0]        op,
  input  logic [2:0]        rs,
  input  logic [2:0]        ra,
  input  logic [2:0]        rb,
  input  logic [3:0]        imm,
  input  logic [5:0]        jaddr,
  input  logic [3:0]        daddr,
  output logic [WORD_W-1:0] word,
  output logic              illegal
);
  logic [BODY_W-1:0] body, s_w, a_w, b_w, i_w, j_w, d_w;
  assign s_w = BODY_W'(rs);
  assign a_w = BODY_W'(ra);
  assign b_w = BODY_W'(rb);
  assign i_w = BODY_W'(imm);
  assign j_w = BODY_W'(jaddr);
  assign d_w = BODY_W'(daddr);
  always_comb begin
    illegal = 1'b0;
    body = '0;
    case (op)
      OP_ADD, OP_SUB: body = (s_w << S3_LO) | (a_w << A3_LO) | b_w;
      OP_ADDI, OP_SUBI: body = (s_w << SI_LO) | (a_w << AI_LO) | i_w;
      OP_MUL, OP_DIV, OP_INC, OP_DEC: body = (s_w << HI_LO) | (a_w << MID_LO);
      OP_CLR, OP_RIO: body = s_w << HI_LO;
      OP_RST: body = '0;
      OP_MOV: body = (s_w << HI_LO) | (b_w << MID_LO);
      OP_JMP, OP_JZ: body = j_w << JADDR_LO;
      OP_CMP: body = (a_w << HI_LO) | (b_w << MID_LO);
      OP_LOAD: body = (s_w << HI_LO) | (d_w << DADDR_LO);
      OP_STORE: body = (a_w << HI_LO) | (d_w << DADDR_LO);
      OP_MOVI: body = (s_w << HI_LO) | (i_w << DADDR_LO);
      default: illegal = 1'b1;
    endcase
  end
  assign word = {op, body};
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams encoded instructions into instruction memory while holding the CPU in reset.
module instr_loader
  import instr_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  instr_loader_if.slave     beat,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [CW-1:0]     count
);
  localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);
  state_t state, state_n;
  logic [WORD_W-1:0] word;
  logic illegal, fire, wr, full;
  instr_packer u_packer (
    .op(beat.op), .rs(beat.rs), .ra(beat.ra), .rb(beat.rb), .imm(beat.imm),
    .jaddr(beat.jaddr), .daddr(beat.daddr), .word(word), .illegal(illegal)
  );
  assign fire = beat.in_valid && beat.in_ready;
  assign wr = fire && !illegal;
  assign full = count == LAST_SLOT;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = start ? ST_LOAD : ST_IDLE;
      ST_LOAD: state_n = fire && (beat.in_last || (!illegal && full)) ? ST_FLUSH : ST_LOAD;
      ST_FLUSH: state_n = ST_DONE;
      default: state_n = ST_IDLE;
    endcase
  end
  always_comb begin
    beat.in_ready = state == ST_LOAD;
    cpu_hold = state != ST_IDLE;
    done = state == ST_DONE;
  end
  // count doubles as the write pointer, so it advances together with imem_we.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      count <= '0;
      err_illegal <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= wr;
      if (state == ST_IDLE && start) begin
        count <= '0;
        err_illegal <= 1'b0;
        err_overflow <= 1'b0;
      end
      if (wr) begin
        imem_addr <= count[AW-1:0];
        imem_wdata <= word;
        count <= count + CW'(1);
      end
      if (fire && illegal) err_illegal <= 1'b1;
      if (wr && !beat.in_last && full) err_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed stimulus against a queue-based model of the loader's writes and flags.
module tb_instr_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic imem_we, cpu_hold, done, err_illegal, err_overflow;
  logic [5:0] imem_addr;
  logic [16:0] imem_wdata;
  logic [6:0] count;
  instr_loader_if bif();
  instr_loader #(.DEPTH(64)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .beat(bif),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err_illegal(err_illegal),
    .err_overflow(err_overflow), .count(count)
  );
  always #5 clk = ~clk;
  typedef struct {int c; logic [5:0] a; logic [16:0] d;} wr_t;
  wr_t q[$];
  logic [5:0] la[$];
  logic [16:0] ld[$];
  int lc[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int m_count = 0;
  int nw = 0;
  logic m_ill = 1'b0;
  logic m_ovf = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  function automatic logic [16:0] enc(input logic [4:0] o, input logic [2:0] s, a, b,
                                      input logic [3:0] im, input logic [5:0] j, input logic [3:0] d);
    case (o)
      5'b00000, 5'b00001: return {o, 3'b0, s, a, b};
      5'b00010, 5'b00011: return {o, 2'b0, s, a, im};
      5'b00100, 5'b00101, 5'b01100, 5'b01101: return {o, s, a, 6'b0};
      5'b00110, 5'b10000: return {o, s, 9'b0};
      5'b01000: return {o, s, b, 6'b0};
      5'b01001, 5'b01011: return {o, j, 6'b0};
      5'b01010: return {o, a, b, 6'b0};
      5'b01110: return {o, s, d, 5'b0};
      5'b01111: return {o, a, d, 5'b0};
      5'b10001: return {o, s, im, 5'b0};
      default: return {o, 12'b0};
    endcase
  endfunction
  always @(negedge clk) if (reset_n) begin
    if (imem_we) begin
      la.push_back(imem_addr);
      ld.push_back(imem_wdata);
      lc.push_back(cyc);
      if (q.size() == 0) chk("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.a));
        chk("wr_data", 32'(imem_wdata), 32'(e.d));
        chk("wr_latency", cyc, e.c);
      end
      m_count++;
    end
    chk("count", 32'(count), m_count);
    chk("err_illegal", 32'(err_illegal), 32'(m_ill));
    chk("err_overflow", 32'(err_overflow), 32'(m_ovf));
  end
  task automatic send(input logic [4:0] o, input logic [2:0] s, a, b, input logic [3:0] im,
                      input logic [5:0] j, input logic [3:0] d, input logic l);
    int w = 0;
    bif.in_valid = 1'b1; bif.in_last = l; bif.op = o; bif.rs = s; bif.ra = a; bif.rb = b;
    bif.imm = im; bif.jaddr = j; bif.daddr = d;
    @(negedge clk);
    while (!bif.in_ready && w < 8) begin w++; @(negedge clk); end
    if (!bif.in_ready) begin
      chk("send_timeout", 32'(bif.in_ready), 32'd1);
      bif.in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (o <= 5'd17) begin
      q.push_back('{c: cyc, a: nw[5:0], d: enc(o, s, a, b, im, j, d)});
      if (!l && nw == 63) m_ovf = 1'b1;
      nw++;
    end else m_ill = 1'b1;
    bif.in_valid = 1'b0;
  endtask
  task automatic do_start;
    chk("idle_ready", 32'(bif.in_ready), 0);
    chk("idle_hold", 32'(cpu_hold), 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_count = 0; nw = 0; m_ill = 1'b0; m_ovf = 1'b0;
    la.delete(); ld.delete(); lc.delete();
    chk("hold_rise", 32'(cpu_hold), 1);
    chk("load_ready", 32'(bif.in_ready), 1);
  endtask
  task automatic wait_done;
    int w = 0;
    @(negedge clk);
    while (!done && w < 20) begin w++; @(negedge clk); end
    chk("done_seen", 32'(done), 1);
    chk("hold_at_done", 32'(cpu_hold), 1);
    chk("ready_at_done", 32'(bif.in_ready), 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("hold_fall", 32'(cpu_hold), 0);
    chk("drained", q.size(), 0);
    @(posedge clk); #1;
  endtask
  task automatic chk_zero(input string p);
    chk({p, "_we"}, 32'(imem_we), 0);
    chk({p, "_addr"}, 32'(imem_addr), 0);
    chk({p, "_wdata"}, 32'(imem_wdata), 0);
    chk({p, "_hold"}, 32'(cpu_hold), 0);
    chk({p, "_done"}, 32'(done), 0);
    chk({p, "_ill"}, 32'(err_illegal), 0);
    chk({p, "_ovf"}, 32'(err_overflow), 0);
    chk({p, "_count"}, 32'(count), 0);
    chk({p, "_ready"}, 32'(bif.in_ready), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
  initial begin
    bif.in_valid = 1'b0; bif.in_last = 1'b0; bif.op = '0; bif.rs = '0; bif.ra = '0; bif.rb = '0;
    bif.imm = '0; bif.jaddr = '0; bif.daddr = '0;
    @(posedge clk); #1;
    chk_zero("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start;
    send(5'b00000, 3, 1, 2, 0, 0, 0, 1);
    wait_done;
    chk("t1_count", 32'(count), 1);
    chk("t1_nwr", la.size(), 1);
    chk("t1_addr", 32'(la[0]), 0);
    chk("t1_data", 32'(ld[0]), 32'h000CA);
    do_start;
    send(5'b01001, 0, 0, 0, 0, 42, 0, 0);
    send(5'b10001, 5, 0, 0, 9, 0, 0, 1);
    wait_done;
    chk("t2_nwr", la.size(), 2);
    chk("t2_addr0", 32'(la[0]), 0);
    chk("t2_data0", 32'(ld[0]), 32'h09A80);
    chk("t2_addr1", 32'(la[1]), 1);
    chk("t2_data1", 32'(ld[1]), 32'h11B20);
    chk("t2_b2b", lc[1] - lc[0], 1);
    do_start;
    send(5'b00000, 1, 2, 3, 0, 0, 0, 0);
    send(5'b10010, 7, 7, 7, 15, 63, 15, 0);
    send(5'b00001, 4, 5, 6, 0, 0, 0, 1);
    wait_done;
    chk("t3_illegal", 32'(err_illegal), 1);
    chk("t3_nwr", la.size(), 2);
    chk("t3_addr1", 32'(la[1]), 1);
    chk("t3_data0", 32'(ld[0]), 32'h00053);
    chk("t3_data1", 32'(ld[1]), 32'h0112E);
    do_start;
    for (int i = 0; i < 64; i++) send(5'b00010, 3'(i % 8), 3'(i / 8), 0, 4'(i % 16), 0, 0, 0);
    bif.in_valid = 1'b1; bif.in_last = 1'b0; bif.op = 5'b00000;
    @(negedge clk);
    chk("t4_ready_drop", 32'(bif.in_ready), 0);
    wait_done;
    bif.in_valid = 1'b0;
    chk("t4_overflow", 32'(err_overflow), 1);
    chk("t4_count", 32'(count), 64);
    chk("t4_nwr", la.size(), 64);
    chk("t4_addr63", 32'(la[63]), 63);
    do_start;
    send(5'b00000, 1, 1, 1, 0, 0, 0, 0);
    send(5'b00100, 2, 3, 0, 0, 0, 0, 0);
    send(5'b01110, 4, 0, 0, 0, 0, 7, 0);
    send(5'b11111, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #2;
    reset_n = 1'b0;
    q.delete(); m_count = 0; nw = 0; m_ill = 1'b0; m_ovf = 1'b0;
    #1;
    chk_zero("arst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_start;
    send(5'b10001, 2, 0, 0, 5, 0, 0, 1);
    wait_done;
    chk("t5_addr0", 32'(la[0]), 0);
    chk("t5_data0", 32'(ld[0]), 32'h114A0);
    chk("t5_illegal", 32'(err_illegal), 0);
    do_start;
    send(5'b01100, 6, 3, 0, 0, 0, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_hold", 32'(cpu_hold), 1);
    chk("t6_ready", 32'(bif.in_ready), 1);
    send(5'b01111, 0, 2, 0, 0, 0, 11, 1);
    wait_done;
    chk("t6_nwr", la.size(), 2);
    chk("t6_addr1", 32'(la[1]), 1);
    chk("t6_data0", 32'(ld[0]), 32'h0CCC0);
    chk("t6_data1", 32'(ld[1]), 32'h0F560);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
